// File: rtl/spi_mem_pkg.sv
// Shared types and constants for the burst-capable SPI slave memory.
package spi_mem_pkg;

  typedef enum logic [1:0] {IDLE, ADDR, WRITE, READ} spi_state_e;

  localparam logic RW_READ     = 1'b1;
  localparam logic RW_WRITE    = 1'b0;
  localparam int   SYNC_STAGES = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_input_sync.sv
// Two-flop synchroniser for one SPI pin, with optional single-cycle edge pulses
// taken from the synchronised level and its one-cycle-delayed copy.
module spi_input_sync
  import spi_mem_pkg::*;
#(
  parameter logic RST_VAL = 1'b0,
  parameter bit   EDGES   = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {SYNC_STAGES{RST_VAL}};
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], din};
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  generate
    if (EDGES) begin : g_edges
      logic prev_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev_q <= RST_VAL;
        else        prev_q <= sync_out;
      end
      assign rise = sync_out & ~prev_q;
      assign fall = ~sync_out & prev_q;
    end else begin : g_no_edges
      assign rise = 1'b0;
      assign fall = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/spi_memory_burst.sv
// SPI slave register memory with burst read/write, address auto-increment and
// wrap, MISO output-enable and abort on chip-select release.
module spi_memory_burst
  import spi_mem_pkg::*;
#(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter int AUTO_INC = 1,
  parameter int LED_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclk_pin,
  input  logic             cs_pin,
  input  logic             mosi_pin,
  output logic             miso_pin,
  output logic             miso_oe,
  output logic [LED_W-1:0] leds,
  output logic             frame_active
);

  localparam int MEM_D = 1 << ADDR_W;
  localparam int CNT_W = $clog2(max_int(ADDR_W + 1, DATA_W)) + 1;
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic unused_sync;

  spi_input_sync #(.RST_VAL(1'b0), .EDGES(1'b1)) u_sclk_sync (
    .clk(clk), .rst_n(rst_n), .din(sclk_pin),
    .sync_out(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_input_sync #(.RST_VAL(1'b1), .EDGES(1'b1)) u_cs_sync (
    .clk(clk), .rst_n(rst_n), .din(cs_pin),
    .sync_out(cs_s), .rise(cs_rise), .fall(cs_fall)
  );

  spi_input_sync #(.RST_VAL(1'b0), .EDGES(1'b0)) u_mosi_sync (
    .clk(clk), .rst_n(rst_n), .din(mosi_pin),
    .sync_out(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
  );

  // Only edges of sclk/cs and the level of mosi drive the datapath.
  assign unused_sync = ^{sclk_s, cs_s, mosi_rise, mosi_fall};

  spi_state_e        state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-2:0] wr_sh;
  logic [DATA_W-1:0] rd_sh;
  logic              load_pend;

  logic [DATA_W-1:0] mem [MEM_D];

  logic [DATA_W-1:0] wr_word;
  logic [DATA_W-1:0] rd_word;
  logic [ADDR_W-1:0] addr_next;
  logic              commit;

  always_comb begin
    wr_word   = {wr_sh, mosi_s};
    rd_word   = mem[addr];
    addr_next = (AUTO_INC != 0) ? addr + ADDR_W'(1) : addr;
    commit    = (state == WRITE) && sclk_rise && (bit_cnt == DATA_LAST);
  end

  // Commit is independent of cs_rise so a final bit landing with CS release still writes.
  always_ff @(posedge clk) begin
    if (commit) mem[addr] <= wr_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      addr         <= '0;
      wr_sh        <= '0;
      rd_sh        <= '0;
      load_pend    <= 1'b0;
      miso_pin     <= 1'b0;
      miso_oe      <= 1'b0;
      leds         <= '0;
      frame_active <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cs_fall) begin
            bit_cnt      <= '0;
            addr         <= '0;
            wr_sh        <= '0;
            frame_active <= 1'b1;
            state        <= ADDR;
          end
        end
        ADDR: begin
          if (sclk_rise) begin
            if (bit_cnt == ADDR_LAST) begin
              bit_cnt   <= '0;
              load_pend <= 1'b1;
              state     <= (mosi_s == RW_READ) ? READ : WRITE;
            end else begin
              addr    <= {addr[ADDR_W-2:0], mosi_s};
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        WRITE: begin
          if (sclk_rise) begin
            wr_sh <= wr_word[DATA_W-2:0];
            if (commit) begin
              leds    <= wr_word[LED_W-1:0];
              addr    <= addr_next;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        READ: begin
          // Rises count bits; the fall after the last rise fetches the next word.
          if (sclk_rise) begin
            if (bit_cnt == DATA_LAST) begin
              bit_cnt   <= '0;
              load_pend <= 1'b1;
              addr      <= addr_next;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          if (sclk_fall) begin
            if (load_pend) begin
              miso_pin  <= rd_word[DATA_W-1];
              rd_sh     <= {rd_word[DATA_W-2:0], 1'b0};
              miso_oe   <= 1'b1;
              load_pend <= 1'b0;
            end else begin
              miso_pin <= rd_sh[DATA_W-1];
              rd_sh    <= {rd_sh[DATA_W-2:0], 1'b0};
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (cs_rise) begin
        state        <= IDLE;
        bit_cnt      <= '0;
        load_pend    <= 1'b0;
        miso_oe      <= 1'b0;
        miso_pin     <= 1'b0;
        frame_active <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_memory_burst.sv
// Directed bench for spi_memory_burst: default build, AUTO_INC=0 build and a
// 4-bit-address / 16-bit-data build, all driven bit-by-bit over SPI pins.
module tb_spi_memory_burst;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       sclk_p [3];
  logic       cs_p   [3];
  logic       mosi_p [3];
  logic       miso_p [3];
  logic       oe_p   [3];
  logic       fa_p   [3];
  logic [3:0] leds_p [3];

  int n_checks = 0;
  int n_pass   = 0;

  spi_memory_burst #(.ADDR_W(7), .DATA_W(8), .AUTO_INC(1), .LED_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .sclk_pin(sclk_p[0]), .cs_pin(cs_p[0]),
    .mosi_pin(mosi_p[0]), .miso_pin(miso_p[0]), .miso_oe(oe_p[0]),
    .leds(leds_p[0]), .frame_active(fa_p[0])
  );

  spi_memory_burst #(.ADDR_W(7), .DATA_W(8), .AUTO_INC(0), .LED_W(4)) dut_fixed (
    .clk(clk), .rst_n(rst_n), .sclk_pin(sclk_p[1]), .cs_pin(cs_p[1]),
    .mosi_pin(mosi_p[1]), .miso_pin(miso_p[1]), .miso_oe(oe_p[1]),
    .leds(leds_p[1]), .frame_active(fa_p[1])
  );

  spi_memory_burst #(.ADDR_W(4), .DATA_W(16), .AUTO_INC(1), .LED_W(4)) dut_wide (
    .clk(clk), .rst_n(rst_n), .sclk_pin(sclk_p[2]), .cs_pin(cs_p[2]),
    .mosi_pin(mosi_p[2]), .miso_pin(miso_p[2]), .miso_oe(oe_p[2]),
    .leds(leds_p[2]), .frame_active(fa_p[2])
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- driver tasks ----------------
  // Each SCLK phase lasts 6 clk; MISO is sampled at the end of the low phase.
  task automatic xfer(input int sel, input logic [31:0] val, input int n,
                      output logic [31:0] rx);
    rx = '0;
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk);
      mosi_p[sel] = val[i];
      repeat (5) @(negedge clk);
      rx = {rx[30:0], miso_p[sel]};
      sclk_p[sel] = 1'b1;
      repeat (6) @(negedge clk);
      sclk_p[sel] = 1'b0;
    end
  endtask

  task automatic frame_start(input int sel, input int aw, input logic [31:0] addr,
                             input logic rw);
    logic [31:0] dummy;
    @(negedge clk);
    cs_p[sel] = 1'b0;
    repeat (5) @(negedge clk);
    xfer(sel, (addr << 1) | {31'd0, rw}, aw + 1, dummy);
  endtask

  task automatic frame_end(input int sel);
    repeat (6) @(negedge clk);
    cs_p[sel] = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] rx;
  logic [7:0]  exp_bits;

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sclk_p[i] = 1'b0;
      cs_p[i]   = 1'b1;
      mosi_p[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("rst_miso", {31'd0, miso_p[0]}, 32'd0);
    check("rst_oe",   {31'd0, oe_p[0]},   32'd0);
    check("rst_leds", {28'd0, leds_p[0]}, 32'd0);
    check("rst_fa",   {31'd0, fa_p[0]},   32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Single write 0x92 to 0x55, then read it back bit by bit.
    frame_start(0, 7, 32'h55, 1'b0);
    check("t1_frame_active", {31'd0, fa_p[0]}, 32'd1);
    xfer(0, 32'h92, 8, rx);
    frame_end(0);
    check("t1_leds", {28'd0, leds_p[0]}, 32'h2);
    check("t1_fa_idle", {31'd0, fa_p[0]}, 32'd0);

    frame_start(0, 7, 32'h55, 1'b1);
    xfer(0, 32'h0, 8, rx);
    check("t1_oe_read", {31'd0, oe_p[0]}, 32'd1);
    frame_end(0);
    exp_bits = 8'b1001_0010;
    for (int i = 0; i < 8; i++)
      check($sformatf("t1_miso_bit%0d", i + 1), {31'd0, rx[7-i]}, {31'd0, exp_bits[7-i]});
    check("t1_oe_after", {31'd0, oe_p[0]}, 32'd0);
    check("t1_miso_after", {31'd0, miso_p[0]}, 32'd0);

    // Burst write across the top of memory, then burst read across the wrap.
    frame_start(0, 7, 32'h7E, 1'b0);
    xfer(0, 32'hA1B2C3, 24, rx);
    frame_end(0);
    check("t2_leds", {28'd0, leds_p[0]}, 32'h3);
    frame_start(0, 7, 32'h7F, 1'b1);
    xfer(0, 32'h0, 16, rx);
    frame_end(0);
    check("t2_burst_read", rx & 32'hFFFF, 32'hB2C3);
    frame_start(0, 7, 32'h7E, 1'b1);
    xfer(0, 32'h0, 8, rx);
    frame_end(0);
    check("t2_read_7e", rx & 32'hFF, 32'hA1);
    frame_start(0, 7, 32'h00, 1'b1);
    xfer(0, 32'h0, 8, rx);
    frame_end(0);
    check("t2_read_00", rx & 32'hFF, 32'hC3);

    // Aborted write: only 5 data bits before CS release.
    frame_start(0, 7, 32'h10, 1'b0);
    xfer(0, 32'h3C, 8, rx);
    frame_end(0);
    check("t3_leds_pre", {28'd0, leds_p[0]}, 32'hC);
    frame_start(0, 7, 32'h10, 1'b0);
    xfer(0, 32'h16, 5, rx);
    frame_end(0);
    check("t3_leds_abort", {28'd0, leds_p[0]}, 32'hC);
    frame_start(0, 7, 32'h10, 1'b1);
    xfer(0, 32'h0, 8, rx);
    frame_end(0);
    check("t3_mem_kept", rx & 32'hFF, 32'h3C);

    // Fixed-address build: two words land on the same location.
    frame_start(1, 7, 32'h06, 1'b0);
    xfer(1, 32'h5A, 8, rx);
    frame_end(1);
    frame_start(1, 7, 32'h05, 1'b0);
    xfer(1, 32'h1122, 16, rx);
    frame_end(1);
    check("t4_leds", {28'd0, leds_p[1]}, 32'h2);
    frame_start(1, 7, 32'h05, 1'b1);
    xfer(1, 32'h0, 16, rx);
    frame_end(1);
    check("t4_read_05_twice", rx & 32'hFFFF, 32'h2222);
    frame_start(1, 7, 32'h06, 1'b1);
    xfer(1, 32'h0, 8, rx);
    frame_end(1);
    check("t4_read_06", rx & 32'hFF, 32'h5A);

    // Wide build: 4-bit address, 16-bit data.
    frame_start(2, 4, 32'hF, 1'b0);
    xfer(2, 32'hBEEF, 16, rx);
    frame_end(2);
    check("t6_leds", {28'd0, leds_p[2]}, 32'hF);
    frame_start(2, 4, 32'hF, 1'b1);
    xfer(2, 32'h0, 16, rx);
    frame_end(2);
    check("t6_read_beef", rx & 32'hFFFF, 32'hBEEF);

    // Reset asserted in the middle of a read word.
    frame_start(0, 7, 32'h55, 1'b1);
    xfer(0, 32'h0, 3, rx);
    repeat (5) @(negedge clk);
    check("t5_first_bits", rx & 32'h7, 32'h4);
    check("t5_miso_pre", {31'd0, miso_p[0]}, 32'd1);
    check("t5_oe_pre", {31'd0, oe_p[0]}, 32'd1);
    rst_n = 1'b0;
    cs_p[0] = 1'b1;
    #1;
    check("t5_rst_miso", {31'd0, miso_p[0]}, 32'd0);
    check("t5_rst_oe",   {31'd0, oe_p[0]},   32'd0);
    check("t5_rst_leds", {28'd0, leds_p[0]}, 32'd0);
    check("t5_rst_fa",   {31'd0, fa_p[0]},   32'd0);
    check("t5_rst_leds_wide", {28'd0, leds_p[2]}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    frame_start(0, 7, 32'h7F, 1'b1);
    check("t5_fa_new", {31'd0, fa_p[0]}, 32'd1);
    xfer(0, 32'h0, 8, rx);
    frame_end(0);
    check("t5_read_after", rx & 32'hFF, 32'hB2);
    check("t5_leds_after", {28'd0, leds_p[0]}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_memory_burst.md
Name: spi_memory_burst

Overview:
- Parametrised SPI slave memory; successor to the fixed 7-bit-address / 8-bit-data SPI memory.
- Adds configurable address and data widths, multi-word burst transfers with address auto-increment and wrap, an explicit MISO output-enable, and clean abort on CS deassert.
- Sits between the board SPI pins and on-chip debug LEDs.
- All SPI pins are asynchronous to clk; they are synchronised internally.

Parameters:
- ADDR_W, 7: address bits per frame; memory depth = 2**ADDR_W.
- DATA_W, 8: bits per data word.
- AUTO_INC, 1: 1 = address increments after each word; 0 = address fixed for the whole frame.
- LED_W, 4: number of low bits of the last written word mirrored on leds; LED_W <= DATA_W.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  reset, asynchronous, active-low.
- sclk_pin  in  1  SPI clock from master; idle level is don't-care.
- cs_pin  in  1  chip select, active-low.
- mosi_pin  in  1  master-out data.
- miso_pin  out  1  slave-out data.
- miso_oe  out  1  high while the slave drives MISO.
- leds  out  LED_W  low LED_W bits of the most recently committed write word.
- frame_active  out  1  high while CS is seen asserted (post-sync).

Behaviour:
- Reset (async, rst_n=0): state=IDLE, bit counter=0, shift registers=0, miso_pin=0, miso_oe=0, leds=0, frame_active=0. Memory contents are not reset.
- Synchronisation: sclk_pin, cs_pin and mosi_pin each pass through a 2-flop synchroniser.
  - sclk and cs additionally have registered edge detectors.
  - Pin-to-action latency is 3 clk cycles.
  - Requirement on the master: SCLK high and low phases >= 4 clk periods; MOSI stable >= 4 clk before the SCLK rise.
- SPI mode: MOSI sampled on synchronised SCLK rising edge; MISO updated on synchronised SCLK falling edge. MSB first throughout.
- Frame format while CS is low:
  - ADDR_W address bits.
  - 1 R/W bit (1 = read, 0 = write).
  - Then any number of DATA_W-bit words.
- State machine:
  - IDLE: wait for CS falling edge. Then clear bit counter, set frame_active=1, go to ADDR.
  - ADDR: shift in ADDR_W bits. On the next rise, sample the R/W bit:
    - R/W=0: go to WRITE.
    - R/W=1: go to READ.
    - Either way, clear the bit counter.
  - WRITE: shift in DATA_W bits. On the final bit's rise:
    - Commit the word to mem[addr] in the same clk cycle.
    - Update leds with the word's low LED_W bits.
    - If AUTO_INC, addr <= addr+1 modulo 2**ADDR_W.
    - Clear the bit counter; stay in WRITE.
  - READ:
    - First SCLK falling edge after the R/W rise: load mem[addr] into the output shifter, drive the MSB on miso_pin, set miso_oe=1.
    - Each subsequent fall: shift and present the next bit.
    - Rises count bits. After DATA_W rises, the next fall loads the following word (addr+1 if AUTO_INC, wrapping) and presents its MSB.
- CS rising edge in any state: return to IDLE.
  - miso_oe=0, miso_pin=0, frame_active=0.
  - A partially shifted write word is discarded; memory and leds are unchanged.
  - A partial address is discarded.
- CS rise coinciding with the final write-bit rise in the same clk cycle: the commit completes, then the block goes to IDLE.
- SCLK edges while CS is high are ignored. A CS fall mid-SCLK-high is legal; the first counted edge is the next rise.
- Memory: 2**ADDR_W x DATA_W register array.
  - Single write port (WRITE commit).
  - Single read port, sampled combinationally at the READ load.
  - No read/write conflict is possible; a frame is either read or write.
- Width rules: address counter is exactly ADDR_W bits (natural wrap); bit counter is $clog2(max(ADDR_W+1, DATA_W))+1 bits.

Decomposition:
- Package spi_mem_pkg:
  - state enum {IDLE, ADDR, WRITE, READ}.
  - RW_READ=1'b1, RW_WRITE=1'b0.
  - SYNC_STAGES=2.
- Sub-module spi_input_sync: 2-flop synchroniser plus optional rise/fall pulse outputs.
  - Three instances: sclk and cs with edges, mosi without.
  - Async active-low reset; reset value 1 for cs, 0 otherwise.

Test Plan:
1. Reset, CS low, address 7'b1010101, R/W=0, data 8'b10010010, CS high -> mem[0x55]=0x92, leds=4'b0010. Then a read frame at 0x55 -> miso bits after falls 1..8 = 1,0,0,1,0,0,1,0; miso_oe=1 during the frame.
2. Burst write starting at 0x7E, words 0xA1, 0xB2, 0xC3 (AUTO_INC=1) -> mem[0x7E]=0xA1, mem[0x7F]=0xB2, mem[0x00]=0xC3 (wrap); leds=4'b0011. Burst read from 0x7F for two words -> 0xB2 then 0xC3.
3. Abort: write frame to 0x10 with only 5 of 8 data bits, then CS high -> mem[0x10] and leds unchanged; next frame decodes correctly from bit 0.
4. AUTO_INC=0 build: write 0x11 then 0x22 in one frame to 0x05 -> mem[0x05]=0x22, mem[0x06] untouched.
5. rst_n pulsed low mid-read (after 3 data bits) -> miso_pin=0, miso_oe=0, leds=0, frame_active=0 immediately; after release plus CS toggle, a new frame works.
6. Parametrised build ADDR_W=4, DATA_W=16: write 0xBEEF to 0xF, read back -> 16 MSB-first bits matching 0xBEEF.
